// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - format-select codes and stage state encoding for imm_gen_stage
package imm_pkg;

    localparam logic [2:0] EXT_I  = 3'b000;
    localparam logic [2:0] EXT_U  = 3'b001;
    localparam logic [2:0] EXT_S  = 3'b010;
    localparam logic [2:0] EXT_B  = 3'b011;
    localparam logic [2:0] EXT_J  = 3'b100;
    localparam logic [2:0] EXT_Z  = 3'b101;
    localparam logic [2:0] EXT_SH = 3'b110;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

endpackage

// File: rtl/imm_gen_stage_if.sv
// rtl/imm_gen_stage_if.sv - upstream/downstream handshake bundle; carries out_err when IMM_ERR_EN is defined
interface imm_gen_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [XLEN-1:0]  in_pc;
    logic [2:0]       in_extop;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [XLEN-1:0]  out_target;
    logic [TAG_W-1:0] out_tag;
`ifdef IMM_ERR_EN
    logic             out_err;

    modport slave (
        input  in_valid, in_instr, in_pc, in_extop, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_target, out_tag, out_err
    );
    modport master (
        output in_valid, in_instr, in_pc, in_extop, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_target, out_tag, out_err
    );
`else
    modport slave (
        input  in_valid, in_instr, in_pc, in_extop, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_target, out_tag
    );
    modport master (
        output in_valid, in_instr, in_pc, in_extop, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_target, out_tag
    );
`endif
endinterface

// File: rtl/imm_format.sv
// rtl/imm_format.sv - combinational immediate extraction and extension to XLEN
module imm_format
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      extop,
    output logic [XLEN-1:0] imm
);

    // Every format is built at 64 bits and truncated, so no zero-width replications appear at XLEN=32.
    logic [63:0] wide;

    always_comb begin
        wide = '0;
        case (extop)
            EXT_I:  wide = {{52{instr[31]}}, instr[31:20]};
            EXT_U:  wide = {{32{instr[31]}}, instr[31:12], 12'h000};
            EXT_S:  wide = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            EXT_B:  wide = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            EXT_J:  wide = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            EXT_Z:  wide = {59'd0, instr[19:15]};
            EXT_SH: wide = (XLEN == 64) ? {58'd0, instr[25:20]} : {59'd0, instr[24:20]};
            default: wide = '0;
        endcase
    end

    assign imm = wide[XLEN-1:0];

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate/target stage with 2-entry skid buffer; IMM_ERR_EN adds out_err
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    imm_gen_stage_if.slave  bus
);

    state_e state_q, state_d;

    logic [XLEN-1:0]  imm_q, imm_d, tgt_q, tgt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  skd_imm_q, skd_imm_d, skd_tgt_q, skd_tgt_d;
    logic [TAG_W-1:0] skd_tag_q, skd_tag_d;
    logic             err_q, err_d, skd_err_q, skd_err_d;

    logic [XLEN-1:0]  new_imm, new_tgt;
    logic             new_err;
    logic             in_ready, out_valid, accept, pop;

    imm_format #(.XLEN(XLEN)) u_format (
        .instr (bus.in_instr[31:7]),
        .extop (bus.in_extop),
        .imm   (new_imm)
    );

    assign new_tgt = bus.in_pc + new_imm;

`ifdef IMM_ERR_EN
    // Without the C extension a control-flow target must be 4-byte aligned.
    assign new_err = (bus.in_extop == 3'b111) ||
                     (((bus.in_extop == EXT_B) || (bus.in_extop == EXT_J)) && new_tgt[1]);
`else
    assign new_err = 1'b0;
`endif

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    always_comb begin
        state_d   = state_q;
        imm_d     = imm_q;
        tgt_d     = tgt_q;
        tag_d     = tag_q;
        err_d     = err_q;
        skd_imm_d = skd_imm_q;
        skd_tgt_d = skd_tgt_q;
        skd_tag_d = skd_tag_q;
        skd_err_d = skd_err_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        imm_d   = new_imm;
                        tgt_d   = new_tgt;
                        tag_d   = bus.in_tag;
                        err_d   = new_err;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (accept && pop) begin
                        imm_d = new_imm;
                        tgt_d = new_tgt;
                        tag_d = bus.in_tag;
                        err_d = new_err;
                    end else if (accept) begin
                        skd_imm_d = new_imm;
                        skd_tgt_d = new_tgt;
                        skd_tag_d = bus.in_tag;
                        skd_err_d = new_err;
                        state_d   = ST_FULL;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        imm_d   = skd_imm_q;
                        tgt_d   = skd_tgt_q;
                        tag_d   = skd_tag_q;
                        err_d   = skd_err_q;
                        state_d = ST_BUSY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            imm_q     <= '0;
            tgt_q     <= '0;
            tag_q     <= '0;
            err_q     <= 1'b0;
            skd_imm_q <= '0;
            skd_tgt_q <= '0;
            skd_tag_q <= '0;
            skd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            imm_q     <= imm_d;
            tgt_q     <= tgt_d;
            tag_q     <= tag_d;
            err_q     <= err_d;
            skd_imm_q <= skd_imm_d;
            skd_tgt_q <= skd_tgt_d;
            skd_tag_q <= skd_tag_d;
            skd_err_q <= skd_err_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_imm    = imm_q;
    assign bus.out_target = tgt_q;
    assign bus.out_tag    = tag_q;
`ifdef IMM_ERR_EN
    assign bus.out_err    = err_q;
`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - scoreboard bench for imm_gen_stage at XLEN 32 and 64; IMM_ERR_EN checks out_err
module tb_imm_gen_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_pop32 = 0;
    bit   rnd_bp = 1'b0;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32), .TAG_W(5)) b32 ();
    imm_gen_stage_if #(.XLEN(64), .TAG_W(5)) b64 ();

    imm_gen_stage #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b32.slave)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (b64.slave)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t e32, e64;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [2:0] ext,
                                   input logic [63:0] pc, input logic [4:0] tag, input int xl);
        exp_t e;
        logic [63:0] imm;
        case (ext)
            3'd0: imm = {{52{ins[31]}}, ins[31:20]};
            3'd1: imm = {{32{ins[31]}}, ins[31:12], 12'h000};
            3'd2: imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            3'd3: imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd4: imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'd5: imm = {59'd0, ins[19:15]};
            3'd6: imm = (xl == 64) ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
            default: imm = 64'd0;
        endcase
        e.imm = imm;
        e.tgt = pc + imm;
        if (xl == 32) begin
            e.imm = {32'd0, e.imm[31:0]};
            e.tgt = {32'd0, e.tgt[31:0]};
        end
        e.tag = tag;
        e.err = (ext == 3'd7) || (((ext == 3'd3) || (ext == 3'd4)) && e.tgt[1]);
        return e;
    endfunction

    // Handshakes are judged at the falling edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                q32.delete();
            end else begin
                if (b32.out_valid && b32.out_ready) begin
                    n_pop32++;
                    if (q32.size() == 0) begin
                        chk("sb32_unexpected_pop", 64'd1, 64'd0);
                    end else begin
                        e32 = q32.pop_front();
                        chk("sb32_imm", {32'd0, b32.out_imm}, e32.imm);
                        chk("sb32_target", {32'd0, b32.out_target}, e32.tgt);
                        chk("sb32_tag", {59'd0, b32.out_tag}, {59'd0, e32.tag});
`ifdef IMM_ERR_EN
                        chk("sb32_err", {63'd0, b32.out_err}, {63'd0, e32.err});
`endif
                    end
                end
                if (b32.in_valid && b32.in_ready)
                    q32.push_back(model(b32.in_instr, b32.in_extop, {32'd0, b32.in_pc}, b32.in_tag, 32));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                q64.delete();
            end else begin
                if (b64.out_valid && b64.out_ready) begin
                    if (q64.size() == 0) begin
                        chk("sb64_unexpected_pop", 64'd1, 64'd0);
                    end else begin
                        e64 = q64.pop_front();
                        chk("sb64_imm", b64.out_imm, e64.imm);
                        chk("sb64_target", b64.out_target, e64.tgt);
                        chk("sb64_tag", {59'd0, b64.out_tag}, {59'd0, e64.tag});
`ifdef IMM_ERR_EN
                        chk("sb64_err", {63'd0, b64.out_err}, {63'd0, e64.err});
`endif
                    end
                end
                if (b64.in_valid && b64.in_ready)
                    q64.push_back(model(b64.in_instr, b64.in_extop, b64.in_pc, b64.in_tag, 64));
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1 b32.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input bit w64, input logic [31:0] ins, input logic [2:0] ext,
                        input logic [63:0] pc, input logic [4:0] tag);
        bit ok = 1'b0;
        if (w64) begin
            b64.in_valid = 1'b1; b64.in_instr = ins; b64.in_extop = ext; b64.in_pc = pc; b64.in_tag = tag;
        end else begin
            b32.in_valid = 1'b1; b32.in_instr = ins; b32.in_extop = ext; b32.in_pc = pc[31:0]; b32.in_tag = tag;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((w64 && b64.in_ready) || (!w64 && b32.in_ready)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        if (w64) b64.in_valid = 1'b0;
        else     b32.in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain32();
        for (int i = 0; i < 200 && q32.size() != 0; i++) step(1);
        chk("drain32_empty", 64'(q32.size()), 64'd0);
    endtask

    initial begin
        b32.in_valid = 0; b32.in_instr = 0; b32.in_pc = 0; b32.in_extop = 0; b32.in_tag = 0; b32.out_ready = 1;
        b64.in_valid = 0; b64.in_instr = 0; b64.in_pc = 0; b64.in_extop = 0; b64.in_tag = 0; b64.out_ready = 1;
        step(3);
        chk("rst_out_valid", {63'd0, b32.out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, b32.in_ready}, 64'd1);
        chk("rst_out_imm", {32'd0, b32.out_imm}, 64'd0);
        chk("rst_out_tag", {59'd0, b32.out_tag}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // Directed format vectors with 1-cycle latency
        send(0, 32'hFFF00093, 3'b000, 64'h0, 5'd1);
        chk("i_valid", {63'd0, b32.out_valid}, 64'd1);
        chk("i_imm", {32'd0, b32.out_imm}, 64'hFFFF_FFFF);
        chk("i_target", {32'd0, b32.out_target}, 64'hFFFF_FFFF);
        send(0, 32'hFE000EE3, 3'b011, 64'h100, 5'd2);
        chk("b_imm", {32'd0, b32.out_imm}, 64'hFFFF_FFFC);
        chk("b_target", {32'd0, b32.out_target}, 64'h0000_00FC);
        send(0, 32'h0080006F, 3'b100, 64'h200, 5'd3);
        chk("j_imm", {32'd0, b32.out_imm}, 64'h8);
        chk("j_target", {32'd0, b32.out_target}, 64'h208);
        send(1, 32'h80000037, 3'b001, 64'h0, 5'd4);
        chk("u64_imm", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
        send(1, 32'h03F00013, 3'b110, 64'h0, 5'd5);
        chk("sh64_imm", b64.out_imm, 64'h3F);
        send(0, 32'h03F00013, 3'b110, 64'h0, 5'd5);
        chk("sh32_imm", {32'd0, b32.out_imm}, 64'h1F);
        send(1, 32'h000F8073, 3'b101, 64'h0, 5'd6);
        chk("z64_imm", b64.out_imm, 64'h1F);
`ifdef IMM_ERR_EN
        send(0, 32'h00000000, 3'b111, 64'h40, 5'd7);
        chk("err_ext111", {63'd0, b32.out_err}, 64'd1);
        send(0, 32'hFE000EE3, 3'b011, 64'h102, 5'd8);
        chk("err_misaligned_b", {63'd0, b32.out_err}, 64'd1);
        send(0, 32'hFE000EE3, 3'b011, 64'h100, 5'd9);
        chk("err_aligned_b", {63'd0, b32.out_err}, 64'd0);
`endif
        step(2);

        // Backpressure: two accepted, third held upstream, then FIFO drain
        b32.out_ready = 1'b0;
        n_pop32 = 0;
        send(0, 32'h00100093, 3'b000, 64'h10, 5'd1);
        send(0, 32'h00200093, 3'b000, 64'h20, 5'd2);
        chk("bp_in_ready_full", {63'd0, b32.in_ready}, 64'd0);
        b32.in_valid = 1'b1; b32.in_instr = 32'h00300093; b32.in_extop = 3'b000; b32.in_pc = 32'h30; b32.in_tag = 5'd3;
        step(3);
        chk("bp_still_full", {63'd0, b32.in_ready}, 64'd0);
        chk("bp_head_tag_stable", {59'd0, b32.out_tag}, 64'd1);
        chk("bp_head_imm_stable", {32'd0, b32.out_imm}, 64'd1);
        b32.out_ready = 1'b1;
        for (int i = 0; i < 20 && !(b32.in_ready); i++) step(1);
        @(negedge clk);
        @(posedge clk);
        #1 b32.in_valid = 1'b0;
        drain32();
        chk("bp_pop_count", 64'(n_pop32), 64'd3);

        // Flush from FULL with a pending input, and from BUSY with a live accept
        b32.out_ready = 1'b0;
        send(0, 32'h00500093, 3'b000, 64'h0, 5'd10);
        send(0, 32'h00600093, 3'b000, 64'h0, 5'd11);
        b32.in_valid = 1'b1; b32.in_tag = 5'd12;
        flush = 1'b1;
        step(1);
        flush = 1'b0; b32.in_valid = 1'b0;
        chk("flush_full_out_valid", {63'd0, b32.out_valid}, 64'd0);
        chk("flush_full_in_ready", {63'd0, b32.in_ready}, 64'd1);
        step(2);
        chk("flush_full_stays_empty", {63'd0, b32.out_valid}, 64'd0);
        send(0, 32'h00700093, 3'b000, 64'h0, 5'd13);
        b32.in_valid = 1'b1; b32.in_tag = 5'd14;
        flush = 1'b1;
        step(1);
        flush = 1'b0; b32.in_valid = 1'b0;
        chk("flush_busy_out_valid", {63'd0, b32.out_valid}, 64'd0);
        b32.out_ready = 1'b1;
        step(2);

        // Asynchronous reset in the middle of a clock phase while BUSY
        b32.out_ready = 1'b0;
        send(0, 32'hFFF00093, 3'b000, 64'h0, 5'd15);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, b32.out_valid}, 64'd0);
        chk("arst_out_imm", {32'd0, b32.out_imm}, 64'd0);
        chk("arst_out_target", {32'd0, b32.out_target}, 64'd0);
        chk("arst_out_tag", {59'd0, b32.out_tag}, 64'd0);
        chk("arst_in_ready", {63'd0, b32.in_ready}, 64'd1);
        q32.delete();
        q64.delete();
        @(negedge clk);
        rst_n = 1'b1;
        b32.out_ready = 1'b1;
        step(1);
        send(0, 32'h0080006F, 3'b100, 64'h200, 5'd16);
        chk("post_rst_valid", {63'd0, b32.out_valid}, 64'd1);
        chk("post_rst_target", {32'd0, b32.out_target}, 64'h208);
        step(1);

        // Random traffic under random backpressure
        rnd_bp = 1'b1;
        for (int i = 0; i < 40; i++)
            send(0, $urandom, 3'($urandom_range(0, 7)), 64'($urandom), 5'(i));
        rnd_bp = 1'b0;
        #2 b32.out_ready = 1'b1;
        drain32();
        for (int i = 0; i < 20; i++)
            send(1, $urandom, 3'($urandom_range(0, 7)), {32'($urandom), 32'($urandom)}, 5'(i));
        step(3);
        chk("drain64_empty", 64'(q64.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Parametrised, pipelined successor to the combinational immediate generator.
- Formats I/U/S/B/J plus CSR-zimm and shift-amount immediates, sign-extended to XLEN.
- Also computes branch/jump target pc+imm.
- Sits between instruction decode and execute as one registered stage with a 2-entry skid buffer and valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 5, width of the opaque sideband tag (e.g. rd index) passed through with each entry.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous flush; drops all buffered entries
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept an entry
- in_instr  input  32  raw instruction word
- in_pc  input  XLEN  PC of the instruction
- in_extop  input  3  format select
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  output entry valid
- out_ready  input  1  downstream accepts entry
- out_imm  output  XLEN  formatted immediate
- out_target  output  XLEN  in_pc + imm, modulo 2^XLEN
- out_tag  output  TAG_W  tag of the output entry

Behaviour:
- ExtOP codes:
  - 000 I: instr[31:20], sign-extended.
  - 001 U: {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
  - 010 S: {instr[31:25], instr[11:7]}, sign-extended.
  - 011 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}, sign-extended.
  - 100 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended.
  - 101 Z: instr[19:15], zero-extended.
  - 110 SH: instr[24:20] zero-extended for XLEN=32; instr[25:20] for XLEN=64.
  - 111: imm = 0.
- Imm and target are computed combinationally on the input side and registered together with the tag; target is computed for every format.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- States: EMPTY, BUSY (main register full), FULL (main + skid full).
- Outputs: in_ready = (state != FULL); out_valid = (state != EMPTY). Both derive from the state register only; there is no combinational path from out_ready to in_ready.
- EMPTY: accept -> main, go BUSY.
- BUSY:
  - Accept & pop -> main <= new, stay BUSY.
  - Accept & !pop -> skid <= new, go FULL.
  - Pop & !accept -> go EMPTY.
  - Otherwise hold.
- FULL: no accept. Pop -> main <= skid, go BUSY. Otherwise hold.
- Latency: an entry accepted at edge N is on the outputs after edge N with out_valid=1 (1 cycle) when the stage was EMPTY, or BUSY with a same-cycle pop.
- Order is strictly FIFO. Output fields are stable while out_valid & !out_ready.
- flush has priority over everything: next state EMPTY, and any same-cycle accept or pop is discarded (no entry is emitted).
- Reset (async assert, any state, including mid-transfer): state EMPTY, out_valid=0, out_imm=0, out_target=0, out_tag=0, skid contents=0, so in_ready=1. Reset deassertion is synchronised externally.
- In EMPTY state the data registers hold their last values; only out_valid is qualified.

Optional Feature:
- IMM_ERR_EN defined:
  - Adds output out_err (1 bit), registered and buffered alongside the entry; reset value 0.
  - out_err=1 when extop==111, or when extop is B or J and out_target[1]=1 (misaligned target without C extension).
- IMM_ERR_EN undefined: the port is absent and no error logic is synthesised.

Decomposition:
- Package imm_pkg holds:
  - ExtOP localparams: EXT_I, EXT_U, EXT_S, EXT_B, EXT_J, EXT_Z, EXT_SH.
  - The 2-bit state encoding: ST_EMPTY=00, ST_BUSY=01, ST_FULL=10.
- Sub-module imm_format (combinational, parameter XLEN): instr and extop -> imm. It is instantiated once on the input side. The skid buffer and adder stay in imm_gen_stage.

Test Plan:
- XLEN=32, out_ready=1; send 0xFFF00093 ext 000 pc 0x0 -> out_imm 0xFFFFFFFF, out_target 0xFFFFFFFF, 1 cycle later.
- Send 0xFE000EE3 ext 011 pc 0x100 -> imm 0xFFFFFFFC, target 0x000000FC. Send 0x0080006F ext 100 pc 0x200 -> imm 0x8, target 0x208.
- XLEN=64: send 0x80000037 ext 001 -> imm 0xFFFFFFFF80000000. Send instr[25:20]=0x3F ext 110 -> imm 0x3F. Send instr[19:15]=0x1F ext 101 -> imm 0x1F.
- out_ready=0; push tags 1, 2, 3 back-to-back -> tags 1 and 2 accepted, in_ready=0 after the 2nd accept, tag 3 held upstream. Release out_ready -> tags emerge in order 1, 2, 3 with no loss or duplication.
- State FULL; assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed-cycle input does not appear.
- Assert rst_n low asynchronously (mid-clock) while BUSY -> out_valid, out_imm, out_target, out_tag = 0 immediately. After release, first accepted entry appears normally. With IMM_ERR_EN: ext 111 gives out_err=1; ext 011 with pc 0x102 gives out_err=1.
